ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader.sv | 160 ++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams configuration words LSB-first into a serial
// ccff chain, then recirculates the chain once to read it back and compares a
// CRC-8 (poly 0x07) of the loaded bits against a CRC-8 of the readback bits.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 28,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] WORD_C = WCNT_W'(WORD_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        FINISH = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;       // word being shifted, bit 0 next
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;       // bits of word_q still pending
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d; // bits shifted (LOAD) / cycles (VERIFY)
    logic [7:0]         crc_q, crc_d;         // CRC of loaded bits
    logic [7:0]         rb_crc_q, rb_crc_d;   // CRC of readback bits
    logic               done_q, done_d;
    logic               error_q, error_d;

    // One serial CRC-8 step, MSB-first register, polynomial x^8+x^2+x+1.
    function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    // Next-state, datapath and output decode; abort overrides everything.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        word_d    = word_q;
        wcnt_d    = wcnt_q;
        bit_cnt_d = bit_cnt_q;
        crc_d     = crc_q;
        rb_crc_d  = rb_crc_q;
        done_d    = done_q;
        error_d   = error_q;
        cfg_ready = 1'b0;
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
        busy      = (state_q != IDLE);

        if (abort) begin
            state_d = IDLE;
            wcnt_d  = '0;
            done_d  = 1'b0;
            error_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = LOAD;
                        wcnt_d    = '0;
                        bit_cnt_d = '0;
                        crc_d     = 8'h00;
                        done_d    = 1'b0;
                        error_d   = 1'b0;
                    end
                end

                LOAD: begin
                    if (bit_cnt_q == LEN_C) begin
                        // Chain full: drop any leftover bits of the last word.
                        state_d   = VERIFY;
                        wcnt_d    = '0;
                        bit_cnt_d = '0;
                        rb_crc_d  = 8'h00;
                    end else if (wcnt_q == '0) begin
                        // Empty shift register: this is the per-word bubble.
                        cfg_ready = 1'b1;
                        if (cfg_valid) begin
                            word_d = cfg_data;
                            wcnt_d = WORD_C;
                        end
                    end else begin
                        ccff_en   = 1'b1;
                        ccff_head = word_q[0];
                        word_d    = word_q >> 1;
                        wcnt_d    = wcnt_q - 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        crc_d     = crc_step(crc_q, word_q[0]);
                    end
                end

                VERIFY: begin
                    // Recirculate tail to head so the chain ends where it began.
                    ccff_en   = 1'b1;
                    ccff_head = ccff_tail;
                    rb_crc_d  = crc_step(rb_crc_q, ccff_tail);
                    if (bit_cnt_q == LAST_C) begin
                        state_d   = FINISH;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end

                FINISH: begin
                    done_d  = 1'b1;
                    error_d = (rb_crc_q != crc_q);
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous clear on pReset.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            wcnt_q    <= '0;
            bit_cnt_q <= '0;
            crc_q     <= 8'h00;
            rb_crc_q  <= 8'h00;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed from the previous state, independent of statement order.
            state_q   <= state_d;
            word_q    <= word_d;
            wcnt_q    <= wcnt_d;
            bit_cnt_q <= bit_cnt_d;
            crc_q     <= crc_d;
            rb_crc_q  <= rb_crc_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: drives word streams into the loader,
// models the 28-flop ccff chain (optionally with flop 13 stuck at 0) and
// checks load/readback results against a bit-level reference.
module tb_ccff_chain_loader;

    localparam int LEN = 28;
    localparam int W   = 8;
    localparam int BUDGET = 400;

    logic           prog_clk = 1'b0;
    logic           pReset;
    logic           start;
    logic           abort;
    logic [W-1:0]   cfg_data;
    logic           cfg_valid;
    logic           cfg_ready;
    logic           ccff_head;
    logic           ccff_en;
    logic           ccff_tail;
    logic           busy;
    logic           done;
    logic           error;

    logic [LEN-1:0] chain;   // chain[0] is next to the head, chain[LEN-1] is the tail
    logic           stuck13;

    int n_vec = 0;
    int n_bad = 0;

    // Per-run observations filled by run_load.
    int             r_acc;
    int             r_en;
    int             r_cyc;
    bit             r_gap_bad;
    bit             r_overlap_bad;
    bit             r_timeout;
    logic [LEN-1:0] r_snap;
    int             base_cyc;

    typedef struct {
        string       name;
        logic [47:0] words;     // word i at [8i +: 8]; six words offered at most
        int          gap_after;
        int          gap_len;
        bit          spam;
        bit          stuck;
        int          delta;     // expected cycles relative to the basic run, -1 = skip
    } vec_t;

    vec_t vecs [6];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(LEN), .WORD_W(W)) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .start     (start),
        .abort     (abort),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .ccff_head (ccff_head),
        .ccff_en   (ccff_en),
        .ccff_tail (ccff_tail),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // Chain model: shifts only when enabled; a stuck flop always reads 0.
    always @(posedge prog_clk) begin
        if (ccff_en)
            chain <= {chain[LEN-2:0], ccff_head} & ~(stuck13 ? (LEN'(1) << 13) : LEN'(0));
    end
    assign ccff_tail = chain[LEN-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Loaded chain contents: stream bit k ends up k flops away from the tail.
    function automatic logic [LEN-1:0] exp_chain(input logic [47:0] words);
        logic [LEN-1:0] c;
        for (int k = 0; k < LEN; k++) c[LEN-1-k] = words[k];
        return c;
    endfunction

    // CRC-8 over the first LEN stream bits.
    function automatic logic [7:0] crc8_bits(input logic [47:0] words);
        logic [7:0] c = 8'h00;
        for (int k = 0; k < LEN; k++)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ words[k]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    // One load operation, cycle by cycle; optional gap, start spamming,
    // random valid dropouts, and an abort or reset injected at a given
    // number of enabled chain cycles.
    task automatic run_load(input logic [47:0] words, input int gap_after, input int gap_len,
                            input bit spam, input bit rand_valid, input int abort_at,
                            input int reset_at);
        int idx = 0;
        int gap_left = 0;
        bit gap_armed = 0;
        bit snap_pending = 0;
        logic [LEN-1:0] held;
        r_acc = 0; r_en = 0; r_cyc = 0;
        r_gap_bad = 0; r_overlap_bad = 0; r_timeout = 0; r_snap = '0;
        @(negedge prog_clk);
        start = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
        @(negedge prog_clk);
        start = spam;
        while (!done) begin
            if (r_cyc >= BUDGET) begin
                r_timeout = 1;
                break;
            end
            if (abort_at > 0 && r_en == abort_at) begin
                abort = 1'b1; start = 1'b1; cfg_valid = 1'b1;
                #1;
                check("abort_en", ccff_en, 0);
                check("abort_ready", cfg_ready, 0);
                @(negedge prog_clk);
                abort = 1'b0; start = 1'b0; cfg_valid = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_error", error, 1);
                @(negedge prog_clk);
                check("abort_start_not_taken", busy, 0);
                return;
            end
            if (reset_at > 0 && r_en == reset_at) begin
                pReset = 1'b1;
                #1;
                check("reset_outputs", {cfg_ready, ccff_en, ccff_head, busy, done, error}, 6'b0);
                held = chain;
                @(negedge prog_clk);
                check("reset_no_shift", chain, held);
                pReset = 1'b0; start = 1'b0; cfg_valid = 1'b0;
                return;
            end
            if (gap_armed && cfg_ready) begin
                gap_armed = 0;
                gap_left  = gap_len;
            end
            cfg_valid = (idx < 6) && (gap_left == 0) && (!rand_valid || ($urandom_range(3) != 0));
            cfg_data  = (idx < 6) ? words[idx*8 +: 8] : 8'h00;
            #1;
            if (gap_left > 0 && ccff_en) r_gap_bad = 1;
            if (cfg_ready && ccff_en) r_overlap_bad = 1;
            if (ccff_en) begin
                r_en++;
                if (r_en == LEN) snap_pending = 1;
            end
            if (cfg_valid && cfg_ready) begin
                idx++;
                r_acc++;
                if (gap_len > 0 && idx == gap_after + 1) gap_armed = 1;
            end
            if (gap_left > 0) gap_left--;
            @(negedge prog_clk);
            r_cyc++;
            if (snap_pending) begin
                r_snap = chain;
                snap_pending = 0;
            end
        end
        start = 1'b0; cfg_valid = 1'b0;
    endtask

    // Checks one completed load against the reference.  With flop 13 stuck,
    // every bit passes through flop 13 during the load or during readback, so
    // the readback stream is all zeros and its CRC is 0.
    task automatic verify_run(input string name, input logic [47:0] words, input bit stuck,
                              input int delta, input int gap_len);
        logic [7:0] crc_load = crc8_bits(words);
        check({name, ":timeout"}, r_timeout, 0);
        check({name, ":accepted"}, r_acc, (LEN + W - 1) / W);
        check({name, ":en_cycles"}, r_en, 2 * LEN);
        check({name, ":en_with_ready"}, r_overlap_bad, 0);
        check({name, ":done_busy"}, {done, busy}, 2'b10);
        check({name, ":error"}, error, stuck && (crc_load != 8'h00));
        if (!stuck) begin
            check({name, ":loaded_chain"}, r_snap, exp_chain(words));
            check({name, ":final_chain"}, chain, exp_chain(words));
        end
        if (gap_len > 0) check({name, ":gap_stall"}, r_gap_bad, 0);
        if (delta >= 0) check({name, ":cycles"}, r_cyc, base_cyc + delta);
    endtask

    initial begin
        vecs[0] = '{"basic",      48'h00_55_0F_FF_3C_A5, 0, 0, 0, 0, -1};
        vecs[1] = '{"stuck13",    48'h00_55_0F_FF_3C_A5, 0, 0, 0, 1,  0};
        vecs[2] = '{"gap",        48'h00_55_0F_FF_3C_A5, 1, 5, 0, 0,  5};
        vecs[3] = '{"spam_start", 48'h00_55_0F_FF_3C_A5, 0, 0, 1, 0,  0};
        vecs[4] = '{"zeros",      48'h00_00_00_00_00_00, 0, 0, 0, 0,  0};
        vecs[5] = '{"ones",       48'hFF_FF_FF_FF_FF_FF, 0, 0, 0, 0,  0};

        pReset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_valid = 1'b0; cfg_data = '0; stuck13 = 1'b0; chain = '0;
        base_cyc = 0;
        repeat (3) @(negedge prog_clk);
        check("reset_state", {cfg_ready, ccff_en, ccff_head, busy, done, error}, 6'b0);
        pReset = 1'b0;
        repeat (3) @(negedge prog_clk);
        check("idle_after_reset", {busy, ccff_en, cfg_ready}, 3'b0);

        for (int i = 0; i < 6; i++) begin
            stuck13 = vecs[i].stuck;
            run_load(vecs[i].words, vecs[i].gap_after, vecs[i].gap_len, vecs[i].spam, 0, 0, 0);
            stuck13 = 1'b0;
            if (i == 0) base_cyc = r_cyc;
            verify_run(vecs[i].name, vecs[i].words, vecs[i].stuck, vecs[i].delta, vecs[i].gap_len);
        end

        // Abort together with start in VERIFY cycle 10, then a clean load.
        run_load(vecs[0].words, 0, 0, 0, 0, LEN + 10, 0);
        run_load(vecs[0].words, 0, 0, 0, 0, 0, 0);
        verify_run("after_abort", vecs[0].words, 0, 0, 0);

        // Reset pulse after 12 loaded bits, then a clean load.
        run_load(vecs[0].words, 0, 0, 0, 0, 0, 12);
        run_load(vecs[0].words, 0, 0, 0, 0, 0, 0);
        verify_run("after_reset", vecs[0].words, 0, 0, 0);

        // Randomized words, gaps, valid dropouts and stuck-flop faults.
        for (int r = 0; r < 16; r++) begin
            logic [47:0] w;
            bit st;
            int ga, gl;
            w  = {16'($urandom), 32'($urandom)};
            st = ($urandom_range(3) == 0);
            ga = $urandom_range(0, 3);
            gl = $urandom_range(0, 8);
            stuck13 = st;
            run_load(w, ga, gl, 0, 1, 0, 0);
            stuck13 = 1'b0;
            verify_run($sformatf("random%0d", r), w, st, -1, gl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
